// File: rtl/usb2_ep_in_packer.sv
// Packs a valid/ready byte stream into the USB 2.0 IN endpoint write buffer and commits packets.
// Optional idle-timeout commit is built when USB2_EP_PACKER_TIMEOUT_EN is defined.
module usb2_ep_in_packer #(
    parameter int unsigned MAX_LEN     = 1024,
    parameter int unsigned TIMEOUT_CYC = 60000
) (
    input  logic        phy_clk,
    input  logic        reset_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_flush,
    output logic [10:0] buf_in_addr,
    output logic [7:0]  buf_in_data,
    output logic        buf_in_wren,
    input  logic        buf_in_ready,
    output logic        buf_in_commit,
    output logic [10:0] buf_in_commit_len,
    input  logic        buf_in_commit_ack,
    output logic [15:0] commit_count,
    output logic        busy
);

    localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 1024) begin : g_bad_max_len
        $error("usb2_ep_in_packer: MAX_LEN out of range 1..1024");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_bad_timeout
        $error("usb2_ep_in_packer: TIMEOUT_CYC out of range 1..65536");
    end

    typedef enum logic [1:0] {
        ST_FILL,
        ST_COMMIT,
        ST_RELEASE
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] len_q, len_d;
    logic        pending_q, pending_d;
    logic [10:0] commit_len_q, commit_len_d;
    logic [15:0] count_q, count_d;
    logic        wren_q;
    logic [10:0] addr_q;
    logic [7:0]  data_q;
    // Holds s_ready low for the first cycle after reset release.
    logic        run_q;

    logic        accept;
    logic [10:0] len_inc;
    logic        timeout_hit;

    assign accept  = s_valid & s_ready;
    assign len_inc = len_q + 11'd1;

`ifdef USB2_EP_PACKER_TIMEOUT_EN
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] idle_q, idle_d;

    always_comb begin
        idle_d      = idle_q + 16'd1;
        timeout_hit = 1'b0;
        if (state_q != ST_FILL || len_q == 11'd0 || accept || pending_q) begin
            idle_d = 16'd0;
        end else if (idle_q == IDLE_LAST) begin
            timeout_hit = 1'b1;
        end
    end

    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= 16'd0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        s_ready = run_q & (state_q == ST_FILL) & buf_in_ready & (len_q < MAX_LEN_W) & ~pending_q;

        state_d      = state_q;
        len_d        = len_q;
        pending_d    = pending_q;
        commit_len_d = commit_len_q;
        count_d      = count_q;

        case (state_q)
            ST_FILL: begin
                if (pending_q) begin
                    // len_q already includes a byte accepted together with the trigger.
                    state_d      = ST_COMMIT;
                    commit_len_d = len_q;
                    pending_d    = 1'b0;
                end else begin
                    if (accept) begin
                        len_d = len_inc;
                    end
                    if ((accept && len_inc == MAX_LEN_W) ||
                        (s_flush && (len_q != 11'd0 || accept)) ||
                        (timeout_hit && len_q != 11'd0)) begin
                        pending_d = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                if (buf_in_commit_ack) begin
                    state_d = ST_RELEASE;
                    count_d = count_q + 16'd1;
                end
            end
            ST_RELEASE: begin
                if (!buf_in_commit_ack) begin
                    state_d = ST_FILL;
                    len_d   = 11'd0;
                end
            end
            default: begin
                state_d   = ST_FILL;
                len_d     = 11'd0;
                pending_d = 1'b0;
            end
        endcase

        buf_in_commit = (state_q == ST_COMMIT);
        busy          = (state_q != ST_FILL);
    end

    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_FILL;
            len_q        <= 11'd0;
            pending_q    <= 1'b0;
            commit_len_q <= 11'd0;
            count_q      <= 16'd0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            pending_q    <= pending_d;
            commit_len_q <= commit_len_d;
            count_q      <= count_d;
            run_q        <= 1'b1;
        end
    end

    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            wren_q <= 1'b0;
            addr_q <= 11'd0;
            data_q <= 8'd0;
        end else begin
            wren_q <= accept;
            if (accept) begin
                addr_q <= len_q;
                data_q <= s_data;
            end
        end
    end

    assign buf_in_wren       = wren_q;
    assign buf_in_addr       = addr_q;
    assign buf_in_data       = data_q;
    assign buf_in_commit_len = commit_len_q;
    assign commit_count      = count_q;

endmodule
